// File: rtl/des_key_sched_dec.sv
// DES decryption key scheduler: emits K16..K1 one per handshake by right-rotating
// the PC-1 halves, so only the current C/D pair is stored.
module des_key_sched_dec #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic [63:0] key_in,
  input  logic        advance,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Tables hold DES bit numbers (1 = MSB) so they read like the standard.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1_TAB[i]);
      r   = {r[54:0], k[idx]};
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2_TAB[i]);
      r   = {r[46:0], cd[idx]};
    end
    return r;
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] h, input logic one);
    return one ? {h[0], h[27:1]} : {h[1:0], h[27:2]};
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  round_q, round_d;
  logic        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [55:0] cd_load;
  logic [27:0] c_rot, d_rot;
  logic        shift_one;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    cd_load   = pc1(key_in);
    // Handshake at round r rotates by SHIFT(r+1); single steps fall at r = 15, 8, 1.
    shift_one = (round_q == 4'd15) || (round_q == 4'd8) || (round_q == 4'd1);
    c_rot     = rotr(c_q, shift_one);
    d_rot     = rotr(d_q, shift_one);

    if (load) begin
      state_d  = ACTIVE;
      c_d      = cd_load[55:28];
      d_d      = cd_load[27:0];
      subkey_d = pc2(cd_load);
      round_d  = 4'(NUM_ROUNDS - 1);
      valid_d  = 1'b1;
      busy_d   = 1'b1;
    end else if (state_q == ACTIVE && valid_q && advance) begin
      if (round_q != 4'd0) begin
        c_d      = c_rot;
        d_d      = d_rot;
        subkey_d = pc2({c_rot, d_rot});
        round_d  = round_q - 4'd1;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign subkey       = subkey_q;
  assign subkey_valid = valid_q;
  assign round        = round_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Directed bench for des_key_sched_dec using the classic 133457799BBCDFF1 key.
module tb_des_key_sched_dec;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        load = 1'b0;
  logic [63:0] key_in = '0;
  logic        advance = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // ks[i] = K(i+1)
  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_sched_dec #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .load         (load),
    .key_in       (key_in),
    .advance      (advance),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_key(input string tag, input int unsigned r);
    check({tag, "_subkey"}, 64'(subkey), 64'(ks[r]));
    check({tag, "_round"}, 64'(round), 64'(r));
    check({tag, "_valid"}, 64'(subkey_valid), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(subkey_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic do_load();
    key_in = KEY;
    load   = 1'b1;
    step();
    load   = 1'b0;
    key_in = 64'hFFFF_0000_A5A5_5A5A;
  endtask

  initial begin
    advance = 1'b1;
    #2;
    check("reset_subkey", 64'(subkey), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check_idle("reset");
    step();
    n_rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("idle");
      check("idle_subkey", 64'(subkey), 64'd0);
    end

    // Full schedule with advance held high, including during load.
    do_load();
    check_key("k16", 15);
    check("k16_busy", 64'(busy), 64'd1);
    for (int r = 14; r >= 0; r--) begin
      step();
      check_key("seq", r);
    end
    step();
    check("end_done", 64'(done), 64'd1);
    check("end_valid", 64'(subkey_valid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("end_subkey_hold", 64'(subkey), 64'(ks[0]));
    check("end_round_hold", 64'(round), 64'd0);
    step();
    check("end_done_clear", 64'(done), 64'd0);

    // Hold without advance.
    advance = 1'b0;
    do_load();
    for (int i = 0; i < 5; i++) begin
      step();
      check_key("hold", 15);
    end
    advance = 1'b1;
    step();
    check_key("after_hold", 14);

    // Reload mid-schedule at round 8.
    for (int i = 0; i < 6; i++) step();
    check_key("pre_reload", 8);
    do_load();
    check_key("reload", 15);
    check("reload_busy", 64'(busy), 64'd1);

    // Load coinciding with the round-0 handshake.
    for (int i = 0; i < 15; i++) step();
    check_key("last", 0);
    do_load();
    check_key("load_at_end", 15);
    step();
    check_key("load_at_end_next", 14);

    // Asynchronous reset at round 4.
    for (int i = 0; i < 10; i++) step();
    check_key("pre_rst", 4);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_subkey", 64'(subkey), 64'd0);
    check("arst_round", 64'(round), 64'd0);
    check_idle("arst");
    step();
    #3;
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("post_rst");
      check("post_rst_subkey", 64'(subkey), 64'd0);
    end
    do_load();
    check_key("post_rst_load", 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
